// File: rtl/crc_pkg.sv
// Shared CRC definitions for the read/write controllers: widths, polynomial,
// FSM state encoding and the single-bit remainder update.
package crc_pkg;

  localparam int DATA_W = 8;
  localparam int CRC_W  = 4;
  localparam int CW_W   = DATA_W + CRC_W;
  localparam int CNT_W  = $clog2(CW_W);

  // Low-order generator terms; the x^CRC_W term is implicit (x^4+x+1).
  localparam logic [CRC_W-1:0] POLY = 4'h3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_LOAD  = 3'd2,
    ST_SHIFT = 3'd3,
    ST_CHECK = 3'd4
  } crc_state_e;

  function automatic logic [CRC_W-1:0] crcStep(input logic [CRC_W-1:0] rem,
                                               input logic              inBit);
    logic fb;
    fb = rem[CRC_W-1] ^ inBit;
    return {rem[CRC_W-2:0], 1'b0} ^ ({CRC_W{fb}} & POLY);
  endfunction

endpackage

// File: rtl/crc_serial_lfsr.sv
// Serial CRC remainder register, one message bit per enabled cycle, MSB first.
// Shared by the encoder and checker datapaths.
module crc_serial_lfsr
  import crc_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             in_bit,
  output logic [CRC_W-1:0] rem
);

  logic [CRC_W-1:0] rem_q;
  logic [CRC_W-1:0] rem_d;

  always_comb begin
    rem_d = rem_q;
    if (clr) begin
      rem_d = '0;
    end else if (en) begin
      rem_d = crcStep(rem_q, in_bit);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rem_q <= '0;
    end else begin
      rem_q <= rem_d;
    end
  end

  assign rem = rem_q;

endmodule

// File: rtl/crc_check_controller.sv
// Read-side CRC checker: fetches one codeword, runs it serially through the
// CRC LFSR and reports the data with an error flag.
module crc_check_controller
  import crc_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              read,
  output logic              read_mem_en,
  input  logic [CW_W-1:0]   mem_rdata,
  output logic              read_mem_busy,
  output logic              read_valid,
  output logic [DATA_W-1:0] read_data,
  output logic              crc_error
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CW_W - 1);

  crc_state_e        state_q;
  logic [CNT_W-1:0]  count_q;
  logic [CW_W-1:0]   shiftReg_q;
  logic [DATA_W-1:0] capData_q;
  logic              readMemEn_q;
  logic              busy_q;
  logic              valid_q;
  logic [DATA_W-1:0] readData_q;
  logic              crcError_q;

  logic [CRC_W-1:0]  rem;
  logic [CRC_W-1:0]  remNext;
  logic              inBit;

  assign inBit = shiftReg_q[CW_W-1];

  crc_serial_lfsr u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .clr    (state_q == ST_LOAD),
    .en     (state_q == ST_SHIFT),
    .in_bit (inBit),
    .rem    (rem)
  );

  // The error flag is latched on the same edge that absorbs the last bit,
  // so it must look at the remainder the LFSR is about to take.
  assign remNext = crcStep(rem, inBit);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      shiftReg_q  <= '0;
      capData_q   <= '0;
      readMemEn_q <= 1'b0;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      readData_q  <= '0;
      crcError_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (read) begin
            state_q     <= ST_READ;
            readMemEn_q <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        ST_READ: begin
          readMemEn_q <= 1'b0;
          state_q     <= ST_LOAD;
        end
        ST_LOAD: begin
          shiftReg_q <= mem_rdata;
          capData_q  <= mem_rdata[CW_W-1:CRC_W];
          count_q    <= '0;
          state_q    <= ST_SHIFT;
        end
        ST_SHIFT: begin
          shiftReg_q <= {shiftReg_q[CW_W-2:0], 1'b0};
          if (count_q == LAST_CNT) begin
            count_q    <= '0;
            state_q    <= ST_CHECK;
            valid_q    <= 1'b1;
            readData_q <= capData_q;
            crcError_q <= |remNext;
          end else begin
            count_q <= count_q + 1'b1;
          end
        end
        ST_CHECK: begin
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q     <= ST_IDLE;
          count_q     <= '0;
          readMemEn_q <= 1'b0;
          busy_q      <= 1'b0;
          valid_q     <= 1'b0;
        end
      endcase
    end
  end

  assign read_mem_en   = readMemEn_q;
  assign read_mem_busy = busy_q;
  assign read_valid    = valid_q;
  assign read_data     = readData_q;
  assign crc_error     = crcError_q;

endmodule

// File: tb/tb_crc_check_controller.sv
// Self-checking bench for crc_check_controller: directed and random reads
// compared against a polynomial-division reference model.
module tb_crc_check_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        read = 1'b0;
  logic        read_mem_en;
  logic [11:0] mem_rdata = '0;
  logic        read_mem_busy;
  logic        read_valid;
  logic [7:0]  read_data;
  logic        crc_error;

  int total = 0;
  int bad   = 0;

  crc_check_controller dut (
    .clk           (clk),
    .rst           (rst),
    .read          (read),
    .read_mem_en   (read_mem_en),
    .mem_rdata     (mem_rdata),
    .read_mem_busy (read_mem_busy),
    .read_valid    (read_valid),
    .read_data     (read_data),
    .crc_error     (crc_error)
  );

  always #5 clk = ~clk;

  // Remainder of the codeword polynomial modulo x^4+x+1 by long division.
  function automatic logic [3:0] polyMod(input logic [11:0] cw);
    logic [11:0] r;
    logic [11:0] g;
    r = cw;
    for (int b = 11; b >= 4; b--) begin
      if (r[b]) begin
        g = 12'h013 << (b - 4);
        r = r ^ g;
      end
    end
    return r[3:0];
  endfunction

  function automatic logic [3:0] refCrc(input logic [7:0] data);
    return polyMod({data, 4'h0});
  endfunction

  function automatic logic refError(input logic [11:0] cw);
    return polyMod(cw) != 4'h0;
  endfunction

  task automatic checkOutput(input string tag, input logic [15:0] obs,
                             input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full read; cycle 1 is the first cycle after read is sampled.
  task automatic applyStimulus(input logic [11:0] cw, input string tag);
    logic [7:0] expData;
    logic       expErr;
    expData = cw[11:4];
    expErr  = refError(cw);
    @(negedge clk);
    mem_rdata = cw;
    read      = 1'b1;
    @(negedge clk);
    read = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      checkOutput({tag, ".en"},    16'(read_mem_en),   16'(k == 1));
      checkOutput({tag, ".busy"},  16'(read_mem_busy), 16'(k <= 15));
      checkOutput({tag, ".valid"}, 16'(read_valid),    16'(k == 15));
      if (k == 15) begin
        checkOutput({tag, ".data"}, 16'(read_data), 16'(expData));
        checkOutput({tag, ".err"},  16'(crc_error), 16'(expErr));
      end
      if (k < 16) @(negedge clk);
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [11:0] cw;
    logic [7:0]  d;

    $display("[TB] reset idle");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      checkOutput("idle.en",    16'(read_mem_en),   16'h0);
      checkOutput("idle.busy",  16'(read_mem_busy), 16'h0);
      checkOutput("idle.valid", 16'(read_valid),    16'h0);
      checkOutput("idle.data",  16'(read_data),     16'h0);
      checkOutput("idle.err",   16'(crc_error),     16'h0);
    end

    $display("[TB] directed reads");
    applyStimulus(12'h013, "clean01");
    applyStimulus(12'h80E, "clean80");
    applyStimulus(12'h000, "zero");
    applyStimulus(12'h012, "err01");
    applyStimulus(12'h90E, "err90");
    checkOutput("err90.hold.data", 16'(read_data), 16'h90);
    checkOutput("err90.hold.err",  16'(crc_error), 16'h1);

    $display("[TB] random reads");
    for (int i = 0; i < 8; i++) begin
      d  = 8'($urandom);
      cw = {d, refCrc(d)};
      if ($urandom_range(0, 1) == 1) cw[$urandom_range(0, 11)] ^= 1'b1;
      applyStimulus(cw, "rand");
    end

    $display("[TB] read held high");
    @(negedge clk);
    mem_rdata = 12'h80E;
    read      = 1'b1;
    for (int k = 1; k <= 48; k++) begin
      @(negedge clk);
      checkOutput("hold.en",    16'(read_mem_en),   16'(k % 16 == 1));
      checkOutput("hold.busy",  16'(read_mem_busy), 16'(k % 16 != 0));
      checkOutput("hold.valid", 16'(read_valid),    16'(k % 16 == 15));
      if (k % 16 == 15) begin
        checkOutput("hold.data", 16'(read_data), 16'h80);
        checkOutput("hold.err",  16'(crc_error), 16'h0);
      end
      if (k == 48) read = 1'b0;
    end

    $display("[TB] reset mid-operation");
    applyStimulus(12'h90E, "pre");
    @(negedge clk);
    mem_rdata = 12'h013;
    read      = 1'b1;
    @(negedge clk);
    read = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    checkOutput("abort.en",    16'(read_mem_en),   16'h0);
    checkOutput("abort.busy",  16'(read_mem_busy), 16'h0);
    checkOutput("abort.valid", 16'(read_valid),    16'h0);
    checkOutput("abort.data",  16'(read_data),     16'h0);
    checkOutput("abort.err",   16'(crc_error),     16'h0);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      checkOutput("abort.quiet.valid", 16'(read_valid),    16'h0);
      checkOutput("abort.quiet.busy",  16'(read_mem_busy), 16'h0);
    end
    applyStimulus(12'h013, "after");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
